// File: rtl/neighbor_fifo_rr_arbiter.sv
// Round-robin read scheduler: drains NUM_REQ neighbor sync FIFOs into one
// downstream port, absorbing the FIFOs' 1-cycle read latency and applying
// backpressure through a 2-entry output buffer.
module neighbor_fifo_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      wclk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        fifo_empty,
  output logic [NUM_REQ-1:0]        fifo_rinc,
  input  logic [NUM_REQ*DATA_W-1:0] fifo_rdata,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int unsigned NREQ = NUM_REQ;

  logic [SRC_W-1:0]  rr_ptr;
  logic              inflight;
  logic [SRC_W-1:0]  inflight_src;

  logic [DATA_W-1:0] buf_data [2];
  logic [SRC_W-1:0]  buf_src  [2];
  logic              rd_idx;
  logic              wr_idx;
  logic [1:0]        buf_cnt;

  logic [DATA_W-1:0] rdata_arr [NUM_REQ];
  logic [SRC_W-1:0]  grant;
  logic              grant_vld;
  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  int unsigned       idx;

  // Split the flat read-data bus into per-FIFO records.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      rdata_arr[i] = fifo_rdata[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin scan: first non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && !fifo_empty[SRC_W'(idx)]) begin
        grant_vld = 1'b1;
        grant     = SRC_W'(idx);
      end
    end
  end

  // Issue only when the buffer is guaranteed to have room for the
  // returning record, counting the read already in flight and this pop.
  always_comb begin
    pop       = out_valid && out_ready;
    occ       = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    issue     = grant_vld && (occ < 3'd2);
    fifo_rinc = '0;
    if (issue) fifo_rinc[grant] = 1'b1;
  end

  // Arbitration state: pointer advance and in-flight read tracking.
  always_ff @(posedge wclk) begin
    if (rst) begin
      rr_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_src <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rr_ptr       <= (grant == SRC_W'(NUM_REQ-1)) ? '0 : grant + SRC_W'(1);
        inflight_src <= grant;
      end
    end
  end

  // 2-entry output buffer: capture returning FIFO data at the tail,
  // retire the head on pop; both may happen in the same cycle.
  always_ff @(posedge wclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_src[i]  <= '0;
      end
      rd_idx  <= 1'b0;
      wr_idx  <= 1'b0;
      buf_cnt <= '0;
    end else begin
      if (inflight) begin
        buf_data[wr_idx] <= rdata_arr[inflight_src];
        buf_src[wr_idx]  <= inflight_src;
        wr_idx           <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({inflight, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Output comes straight from the registered buffer head.
  always_comb begin
    out_valid = (buf_cnt != 2'd0);
    out_data  = buf_data[rd_idx];
    out_src   = buf_src[rd_idx];
    busy      = (|(~fifo_empty)) || inflight || (buf_cnt != 2'd0);
  end

endmodule

// File: tb/tb_neighbor_fifo_rr_arbiter.sv
// Bench for neighbor_fifo_rr_arbiter: behavioural FIFOs plus a
// transaction-level reference (grant order, outstanding count, 2-cycle
// minimum latency, in-order delivery).
module tb_neighbor_fifo_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  localparam int SRC_W   = 2;

  logic                      wclk = 1'b0;
  logic                      rst  = 1'b1;
  logic [NUM_REQ-1:0]        fifo_empty = '1;
  logic [NUM_REQ-1:0]        fifo_rinc;
  logic [NUM_REQ*DATA_W-1:0] fifo_rdata = '0;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  logic                      out_ready = 1'b0;
  logic                      busy;

  neighbor_fifo_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .SRC_W  (SRC_W)
  ) dut (
    .wclk      (wclk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rinc (fifo_rinc),
    .fifo_rdata(fifo_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int          t;
    logic [63:0] d;
    int          s;
  } rec_t;

  logic [63:0] q [NUM_REQ][$];
  rec_t        oq[$];
  int          cyc   = 0;
  int          nxt   = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int f, input logic [63:0] d);
    q[f].push_back(d);
  endtask

  // One clock cycle: check DUT against the reference at the negedge, then
  // advance the FIFO model and the reference just after the posedge.
  task automatic step(input logic rdy, input logic r);
    logic [NUM_REQ-1:0] exp_rinc;
    logic               exp_valid;
    logic               pop_s;
    int                 g;
    int                 j;
    rec_t               e;
    out_ready = rdy;
    rst       = r;
    for (int i = 0; i < NUM_REQ; i++) fifo_empty[i] = (q[i].size() == 0);
    @(negedge wclk);
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (nxt + k) % NUM_REQ;
      if (g < 0 && q[j].size() > 0) g = j;
    end
    exp_valid = (oq.size() > 0) && (oq[0].t + 2 <= cyc);
    pop_s     = exp_valid && rdy;
    exp_rinc  = '0;
    if (g >= 0 && (oq.size() - (pop_s ? 1 : 0)) < 2) exp_rinc = NUM_REQ'(1 << g);
    chk("rinc", 64'(fifo_rinc), 64'(exp_rinc));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("out_data", out_data, oq[0].d);
      chk("out_src", 64'(out_src), 64'(oq[0].s));
    end
    chk("busy", 64'(busy), 64'((g >= 0) || (oq.size() > 0)));
    @(posedge wclk);
    #1;
    fifo_rdata = '0;
    if (r) begin
      for (int i = 0; i < NUM_REQ; i++) q[i].delete();
      oq.delete();
      nxt = 0;
    end else begin
      if (pop_s) oq.delete(0);
      if (exp_rinc != '0) begin
        e.t = cyc;
        e.s = g;
        e.d = q[g].pop_front();
        fifo_rdata[g*DATA_W +: DATA_W] = e.d;
        oq.push_back(e);
        nxt = (g + 1) % NUM_REQ;
      end
    end
    cyc++;
  endtask

  initial begin
    // Reset held three cycles with every FIFO empty.
    rst = 1'b1;
    repeat (2) @(posedge wclk);
    #1;
    step(1'b0, 1'b1);
    chk("rst_data", out_data, 64'h0);
    chk("rst_src", 64'(out_src), 64'h0);
    step(1'b0, 1'b0);

    // Single source: FIFO 2 holds A,B,C.
    push(2, 64'hA); push(2, 64'hB); push(2, 64'hC);
    repeat (7) step(1'b1, 1'b0);

    // Fairness: two records in every FIFO.
    for (int i = 0; i < NUM_REQ; i++) begin
      push(i, 64'h100 + 64'(i));
      push(i, 64'h200 + 64'(i));
    end
    repeat (12) step(1'b1, 1'b0);

    // Backpressure: FIFOs 0 and 1 non-empty, downstream stalled.
    push(0, 64'h300); push(0, 64'h301);
    push(1, 64'h310); push(1, 64'h311);
    repeat (6) step(1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0);

    // Wrap: grant 2, then only FIFOs 0 and 3 pending.
    push(2, 64'h402);
    step(1'b1, 1'b0);
    push(0, 64'h400); push(3, 64'h403);
    repeat (6) step(1'b1, 1'b0);

    // Reset the cycle after a read increment.
    push(1, 64'h501); push(1, 64'h502);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);

    // Randomized traffic with random backpressure and occasional reset.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q[i].size() < 4 && $urandom_range(0, 2) == 0)
          push(i, {$urandom, $urandom});
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
    end
    repeat (25) step(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
